// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and MEM-stage loads/stores onto one
// byte-wide synchronous RAM. Each request is split into byte cycles, and the
// data is assembled or split little-endian. MEM requests win over fetch.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; a new request may be granted
// IF_RD  | fetch: 4 address cycles, then one cycle for the last byte
// MEM_RD | load: N address cycles, then one cycle for the last byte
// MEM_WR | store: N write cycles; ready follows the last write
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_read,
    input  logic [31:0]       if_addr,
    input  logic              if_cancel,
    output logic              if_busy,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              mem_req, if_req;
    logic [1:0]        byte_sel;

    // Len 3 is served as a full word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'd0:    len_to_n = 3'd1;
            2'd1:    len_to_n = 3'd2;
            default: len_to_n = 3'd4;
        endcase
    endfunction

    // A requester seeing its ready pulse this cycle is masked so the same
    // (still held) request is not granted a second time.
    assign mem_req  = (mem_read | mem_write) & ~mem_ready_q;
    assign if_req   = if_read & ~if_cancel & ~if_ready_q;
    // Byte arriving on ram_din belongs to the address issued one cycle earlier.
    assign byte_sel = 2'(cnt_q - 3'd1);

    assign if_busy   = (state_q != IDLE);
    assign mem_busy  = (state_q != IDLE);
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

    // Next-state, datapath and RAM-side outputs; RAM outputs are decoded from
    // state so an asynchronous reset forces them to 0 immediately.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        ram_rw      = 1'b0;
        ram_a       = '0;
        ram_dout    = 8'd0;

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d  = mem_write ? MEM_WR : MEM_RD;
                    cnt_d    = 3'd0;
                    nbytes_d = len_to_n(mem_len);
                    addr_d   = ADDR_W'(mem_addr);
                    wdata_d  = mem_wdata;
                    rbuf_d   = 32'd0;
                end else if (if_req) begin
                    state_d  = IF_RD;
                    cnt_d    = 3'd0;
                    nbytes_d = 3'd4;
                    addr_d   = ADDR_W'(if_addr);
                    rbuf_d   = 32'd0;
                end
            end

            IF_RD, MEM_RD: begin
                if (cnt_q < nbytes_q) begin
                    ram_a = addr_q + ADDR_W'(cnt_q);
                end
                if (cnt_q != 3'd0) begin
                    rbuf_d[{byte_sel, 3'b000} +: 8] = ram_din;
                end
                cnt_d = cnt_q + 3'd1;
                if (state_q == IF_RD && if_cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == nbytes_q) begin
                    state_d = IDLE;
                    if (state_q == IF_RD) begin
                        if_data_d  = rbuf_d;
                        if_ready_d = 1'b1;
                    end else begin
                        mem_rdata_d = rbuf_d;
                        mem_ready_d = 1'b1;
                    end
                end
            end

            MEM_WR: begin
                ram_rw   = 1'b1;
                ram_a    = addr_q + ADDR_W'(cnt_q);
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == nbytes_q - 3'd1) begin
                    state_d     = IDLE;
                    mem_ready_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model and a
// scoreboard queue of expected transfer results.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read, if_cancel;
    logic [31:0] if_addr;
    logic        if_busy, if_ready;
    logic [31:0] if_data;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic        mem_busy, mem_ready;
    logic [31:0] mem_rdata;
    logic        ram_rw;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic [7:0]  ram [0:131071];
    logic        pl_we = 1'b0;
    logic [16:0] pl_a = '0;
    logic [7:0]  pl_d = '0;
    logic [16:0] wlog_a [0:63];
    logic [7:0]  wlog_d [0:63];
    int          wcnt = 0;

    int n_pass = 0;
    int n_checks = 0;

    typedef struct packed {
        logic        is_mem;
        logic        is_wr;
        logic [16:0] a;
        logic [31:0] data;
        logic [7:0]  edges;
    } exp_t;
    exp_t sb[$];

    mem_ctrl #(.ADDR_W(17)) dut (
        .clk(clk), .reset(reset),
        .if_read(if_read), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_busy(if_busy), .if_ready(if_ready), .if_data(if_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ram_rw(ram_rw), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (ram_rw) begin
            ram[ram_a]         <= ram_dout;
            wlog_a[wcnt % 64]  <= ram_a;
            wlog_d[wcnt % 64]  <= ram_dout;
            wcnt               <= wcnt + 1;
        end
        ram_din <= ram[ram_a];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic push_exp(input logic is_mem, input logic is_wr, input logic [31:0] a,
                            input logic [31:0] data, input int edges);
        exp_t e;
        e.is_mem = is_mem;
        e.is_wr  = is_wr;
        e.a      = a[16:0];
        e.data   = data;
        e.edges  = 8'(edges);
        sb.push_back(e);
    endtask

    task automatic drive_mem(input logic wr, input logic [31:0] a, input logic [1:0] len,
                             input logic [31:0] wd);
        mem_read  = ~wr;
        mem_write = wr;
        mem_addr  = a;
        mem_len   = len;
        mem_wdata = wd;
    endtask

    // Called on the negedge where the request was driven. Pops the expected
    // result, follows the transfer and compares latency (edges after grant),
    // first address cycle and data. With tail set, the request is held through
    // the ready cycle to confirm it is not granted again.
    task automatic serve(input string tag, input bit tail);
        exp_t e;
        int   lat;
        bit   seen;
        e    = sb.pop_front();
        seen = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({tag, "_addr"}, 32'(ram_a), 32'(e.a));
                check({tag, "_rw"}, 32'(ram_rw), 32'(e.is_wr));
                check({tag, "_busy"}, 32'(e.is_mem ? mem_busy : if_busy), 32'd1);
            end
            if ((e.is_mem ? mem_ready : if_ready) === 1'b1) begin
                seen = 1'b1;
                lat  = c - 1;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(e.edges));
        if (seen) begin
            if (!e.is_wr)
                check({tag, "_data"}, e.is_mem ? mem_rdata : if_data, e.data);
            check({tag, "_bus_idle"}, 32'({ram_rw, ram_a}), 32'd0);
            check({tag, "_busy_done"}, 32'(e.is_mem ? mem_busy : if_busy), 32'd0);
        end
        if (tail) begin
            @(negedge clk);
            check({tag, "_pulse"}, 32'(e.is_mem ? mem_ready : if_ready), 32'd0);
            check({tag, "_no_regrant"}, 32'(e.is_mem ? mem_busy : if_busy), 32'd0);
        end
        if (e.is_mem) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end else begin
            if_read = 1'b0;
        end
    endtask

    initial begin
        int  base;
        bit  seen;
        reset     = 1'b1;
        if_read   = 1'b0;
        if_cancel = 1'b0;
        if_addr   = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'd0;
        mem_len   = 2'd0;
        mem_wdata = 32'd0;
        @(negedge clk);

        poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h00); poke(17'h103, 8'h00);
        poke(17'h022, 8'h5A);
        poke(17'h300, 8'h11); poke(17'h301, 8'h22); poke(17'h302, 8'h33); poke(17'h303, 8'h44);
        poke(17'h400, 8'h93); poke(17'h401, 8'h00); poke(17'h402, 8'h10); poke(17'h403, 8'h00);
        poke(17'h180, 8'h01); poke(17'h181, 8'h02); poke(17'h182, 8'h03); poke(17'h183, 8'h04);
        poke(17'h200, 8'h6F); poke(17'h201, 8'h00); poke(17'h202, 8'h00); poke(17'h203, 8'h00);
        for (int i = 0; i < 4; i++) poke(17'(32'h500 + i), 8'hAA);

        check("rst_busy", 32'({if_busy, mem_busy}), 32'd0);
        check("rst_ready", 32'({if_ready, mem_ready}), 32'd0);
        check("rst_ram", 32'({ram_rw, ram_a, ram_dout}), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Word fetch
        if_read = 1'b1;
        if_addr = 32'h100;
        push_exp(1'b0, 1'b0, 32'h100, 32'h0000_0513, 5);
        serve("fetch100", 1'b1);

        // Half-word store
        base = wcnt;
        drive_mem(1'b1, 32'h20, 2'd1, 32'hDEAD_BEEF);
        push_exp(1'b1, 1'b1, 32'h20, 32'd0, 2);
        serve("wr_half", 1'b1);
        check("wr_half_count", 32'(wcnt - base), 32'd2);
        check("wr_half_b0", {15'd0, wlog_a[base % 64], wlog_d[base % 64]}, {15'd0, 17'h20, 8'hEF});
        check("wr_half_b1", {15'd0, wlog_a[(base + 1) % 64], wlog_d[(base + 1) % 64]}, {15'd0, 17'h21, 8'hBE});
        check("wr_half_untouched", 32'(ram[17'h22]), 32'h5A);

        // Byte load of the byte just written
        drive_mem(1'b0, 32'h21, 2'd0, 32'd0);
        push_exp(1'b1, 1'b0, 32'h21, 32'h0000_00BE, 2);
        serve("rd_byte", 1'b1);

        // Simultaneous MEM word load and fetch: MEM first, fetch right after
        drive_mem(1'b0, 32'h300, 2'd2, 32'd0);
        if_read = 1'b1;
        if_addr = 32'h400;
        push_exp(1'b1, 1'b0, 32'h300, 32'h4433_2211, 5);
        push_exp(1'b0, 1'b0, 32'h400, 32'h0010_0093, 5);
        serve("both_mem", 1'b0);
        serve("both_fetch", 1'b1);

        // Fetch cancelled in its second cycle
        if_read = 1'b1;
        if_addr = 32'h180;
        @(negedge clk);
        check("cancel_addr", 32'(ram_a), 32'h180);
        @(negedge clk);
        if_cancel = 1'b1;
        if_read   = 1'b0;
        @(negedge clk);
        check("cancel_idle", 32'({if_busy, if_ready}), 32'd0);
        if_cancel = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if_ready === 1'b1) seen = 1'b1;
        end
        check("cancel_no_ready", 32'(seen), 32'd0);
        check("cancel_data_held", if_data, 32'h0010_0093);

        if_read = 1'b1;
        if_addr = 32'h200;
        push_exp(1'b0, 1'b0, 32'h200, 32'h0000_006F, 5);
        serve("fetch200", 1'b1);

        // Reset in the middle of a word store, after the first byte
        base = wcnt;
        drive_mem(1'b1, 32'h500, 2'd2, 32'h4433_2211);
        @(negedge clk);
        check("rstwr_first", 32'({ram_rw, ram_a}), {14'd0, 1'b1, 17'h500});
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstwr_ram", 32'({ram_rw, ram_a, ram_dout}), 32'd0);
        check("rstwr_busy", 32'({if_busy, mem_busy, if_ready, mem_ready}), 32'd0);
        check("rstwr_data", if_data | mem_rdata, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_write = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        check("rstwr_no_ready", 32'(seen), 32'd0);
        check("rstwr_count", 32'(wcnt - base), 32'd1);
        check("rstwr_b0", 32'(ram[17'h500]), 32'h11);
        check("rstwr_b1", 32'(ram[17'h501]), 32'hAA);

        drive_mem(1'b0, 32'h500, 2'd1, 32'd0);
        push_exp(1'b1, 1'b0, 32'h500, 32'h0000_AA11, 3);
        serve("rd_after_rst", 1'b1);

        // Address wrap at the top of RAM; upper address bits are dropped
        base = wcnt;
        drive_mem(1'b1, 32'h0003_FFFF, 2'd1, 32'h0000_CDAB);
        push_exp(1'b1, 1'b1, 32'h1FFFF, 32'd0, 2);
        serve("wr_wrap", 1'b1);
        check("wr_wrap_b0", {15'd0, wlog_a[base % 64], wlog_d[base % 64]}, {15'd0, 17'h1FFFF, 8'hAB});
        check("wr_wrap_b1", {15'd0, wlog_a[(base + 1) % 64], wlog_d[(base + 1) % 64]}, {15'd0, 17'h0, 8'hCD});

        drive_mem(1'b0, 32'h0001_FFFF, 2'd1, 32'd0);
        push_exp(1'b1, 1'b0, 32'h1FFFF, 32'h0000_CDAB, 3);
        serve("rd_wrap", 1'b1);

        // len 3 behaves as a word
        drive_mem(1'b0, 32'h300, 2'd3, 32'd0);
        push_exp(1'b1, 1'b0, 32'h300, 32'h4433_2211, 5);
        serve("rd_len3", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
